// File: rtl/i2s_frame_sequencer.sv
// Master-mode I2S frame sequencer: generates ws and slot timing and paces the
// serial sides of the Tx and Rx FIFOs; stops only on a frame boundary.
module i2s_frame_sequencer #(
    parameter int CNT_W  = 5,
    parameter int FCNT_W = 16
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        standard,
    input  logic              frame_size,
    input  logic [1:0]        word_size,
    input  logic              stereo,
    input  logic              tx_empty,
    input  logic              rx_full,
    output logic              ws,
    output logic              tx_rd_en,
    output logic              tx_mask,
    output logic              rx_wr_en,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              busy,
    output logic              underrun,
    output logic              overflow,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, LEAD, RUN, STOPPING} state_t;

    state_t            state;
    logic              philips_q;
    logic              lsb_q;
    logic              long_slot_q;
    logic              stereo_q;
    logic [CNT_W:0]    word_len_q;
    logic              chan;
    logic              skip_frame;
    logic              skip_slot;

    logic [CNT_W:0]    req_slot_len;
    logic [CNT_W:0]    req_word_len;
    logic [CNT_W:0]    slot_len;
    logic              starting;
    logic              last_bit;
    logic              roll;
    logic              frame_end;
    logic              new_frame;
    logic [CNT_W-1:0]  nxt_bit;
    logic              nxt_chan;
    logic              slot_active;
    logic              skip_frame_n;
    logic              skip_slot_n;
    logic              in_word;
    logic              ws_n;

    // Next-cycle slot position; LEAD is treated as the roll into left bit 0.
    always_comb begin
        req_slot_len = frame_size ? (CNT_W+1)'(32) : (CNT_W+1)'(16);
        case (word_size)
            2'd0:    req_word_len = (CNT_W+1)'(16);
            2'd1:    req_word_len = (CNT_W+1)'(24);
            default: req_word_len = (CNT_W+1)'(32);
        endcase
        if (req_word_len > req_slot_len)
            req_word_len = req_slot_len;

        slot_len     = long_slot_q ? (CNT_W+1)'(32) : (CNT_W+1)'(16);
        starting     = (state == LEAD);
        last_bit     = ~starting && ({1'b0, bit_cnt} == slot_len - 1'b1);
        roll         = starting | last_bit;
        frame_end    = last_bit & chan;
        new_frame    = starting | frame_end;
        nxt_bit      = roll ? '0 : bit_cnt + 1'b1;
        nxt_chan     = starting ? 1'b0 : (last_bit ? ~chan : chan);
        slot_active  = ~nxt_chan | stereo_q;
        skip_frame_n = new_frame ? tx_empty : skip_frame;
        skip_slot_n  = roll ? (slot_active & rx_full) : skip_slot;

        if (lsb_q)
            in_word = ({1'b0, nxt_bit} >= slot_len - word_len_q);
        else
            in_word = ({1'b0, nxt_bit} < word_len_q);

        // Philips announces the next channel one bit early.
        if (philips_q && ({1'b0, nxt_bit} == slot_len - 1'b1))
            ws_n = ~nxt_chan;
        else
            ws_n = nxt_chan;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state       <= IDLE;
            philips_q   <= 1'b0;
            lsb_q       <= 1'b0;
            long_slot_q <= 1'b0;
            stereo_q    <= 1'b0;
            word_len_q  <= '0;
            chan        <= 1'b0;
            skip_frame  <= 1'b0;
            skip_slot   <= 1'b0;
            ws          <= 1'b1;
            tx_rd_en    <= 1'b0;
            tx_mask     <= 1'b1;
            rx_wr_en    <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            underrun <= 1'b0;
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state       <= LEAD;
                        philips_q   <= (standard == 2'd0);
                        lsb_q       <= (standard == 2'd2);
                        long_slot_q <= frame_size;
                        stereo_q    <= stereo;
                        word_len_q  <= req_word_len;
                        chan        <= 1'b0;
                        bit_cnt     <= '0;
                        busy        <= 1'b1;
                        frame_cnt   <= '0;
                        ws          <= (standard != 2'd0);
                        tx_rd_en    <= 1'b0;
                        rx_wr_en    <= 1'b0;
                        tx_mask     <= 1'b1;
                    end
                end
                default: begin
                    if (frame_end)
                        frame_cnt <= frame_cnt + 1'b1;
                    if (frame_end && (state == STOPPING || stop)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ws       <= 1'b1;
                        tx_rd_en <= 1'b0;
                        rx_wr_en <= 1'b0;
                        tx_mask  <= 1'b1;
                        bit_cnt  <= '0;
                        chan     <= 1'b0;
                    end else begin
                        if (state == LEAD)
                            state <= RUN;
                        else if (stop)
                            state <= STOPPING;
                        bit_cnt    <= nxt_bit;
                        chan       <= nxt_chan;
                        skip_frame <= skip_frame_n;
                        skip_slot  <= skip_slot_n;
                        underrun   <= new_frame & tx_empty;
                        overflow   <= roll & slot_active & rx_full;
                        ws         <= ws_n;
                        tx_rd_en   <= slot_active & ~skip_frame_n;
                        rx_wr_en   <= slot_active & ~skip_slot_n;
                        tx_mask    <= ~(slot_active & ~skip_frame_n & in_word);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Scoreboard bench for i2s_frame_sequencer: a time-indexed frame model predicts
// every output for the next cycle; predictions are queued and compared after the edge.
module tb_i2s_frame_sequencer;

    logic        sclk = 1'b0;
    logic        rst, start, stop, frame_size, stereo, tx_empty, rx_full;
    logic [1:0]  standard, word_size;
    logic        ws, tx_rd_en, tx_mask, rx_wr_en, busy, underrun, overflow;
    logic [4:0]  bit_cnt;
    logic [15:0] frame_cnt;

    always #5 sclk = ~sclk;

    i2s_frame_sequencer #(.CNT_W(5), .FCNT_W(16)) dut (
        .sclk(sclk), .rst(rst), .start(start), .stop(stop),
        .standard(standard), .frame_size(frame_size), .word_size(word_size),
        .stereo(stereo), .tx_empty(tx_empty), .rx_full(rx_full),
        .ws(ws), .tx_rd_en(tx_rd_en), .tx_mask(tx_mask), .rx_wr_en(rx_wr_en),
        .bit_cnt(bit_cnt), .busy(busy), .underrun(underrun), .overflow(overflow),
        .frame_cnt(frame_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] pack(input logic e_ws, e_rd, e_mask, e_wr,
                                         input int e_bc, input logic e_busy, e_ur, e_ov,
                                         input logic [15:0] e_fc);
        logic [4:0] bc;
        bc = e_bc[4:0];
        return {4'b0, e_ws, e_rd, e_mask, e_wr, bc, e_busy, e_ur, e_ov, e_fc};
    endfunction

    logic [31:0] exp_q[$];

    bit          m_run, m_stopping, m_skip, m_ovf, m_phil, m_lsb, m_st;
    int          m_t, m_len, m_wlen;
    logic [15:0] m_fcnt = '0;

    // Positions are derived from cycles since start: cycle 1 = LEAD, cycle 2 = left bit 0.
    task automatic model_step();
        logic [31:0] e;
        bit frame_last, ch, act, ur, ov, inword, e_ws;
        int q, b;
        if (rst) begin
            m_run  = 0;
            m_fcnt = '0;
            e = pack(1, 0, 1, 0, 0, 0, 0, 0, '0);
        end else if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_t = 1; m_stopping = 0;
                m_phil = (standard == 2'd0);
                m_lsb  = (standard == 2'd2);
                m_st   = stereo;
                m_len  = frame_size ? 32 : 16;
                m_wlen = (word_size == 2'd0) ? 16 : (word_size == 2'd1) ? 24 : 32;
                if (m_wlen > m_len) m_wlen = m_len;
                m_fcnt = '0;
                e = pack(!m_phil, 0, 1, 0, 0, 1, 0, 0, m_fcnt);
            end else begin
                e = pack(1, 0, 1, 0, 0, 0, 0, 0, m_fcnt);
            end
        end else begin
            frame_last = (m_t >= 2) && (((m_t - 2) % (2 * m_len)) == 2 * m_len - 1);
            if (stop && m_t >= 2) m_stopping = 1;
            if (frame_last) m_fcnt++;
            if (frame_last && m_stopping) begin
                m_run = 0;
                e = pack(1, 0, 1, 0, 0, 0, 0, 0, m_fcnt);
            end else begin
                m_t++;
                q  = (m_t - 2) % (2 * m_len);
                ch = (q >= m_len);
                b  = q % m_len;
                act = !ch || m_st;
                ur = 0; ov = 0;
                if (q == 0) begin m_skip = tx_empty; ur = tx_empty; end
                if (b == 0) begin m_ovf = act && rx_full; ov = m_ovf; end
                inword = m_lsb ? (b >= m_len - m_wlen) : (b < m_wlen);
                e_ws = (m_phil && b == m_len - 1) ? !ch : ch;
                e = pack(e_ws, act && !m_skip, !(act && !m_skip && inword),
                         act && !m_ovf, b, 1, ur, ov, m_fcnt);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        logic [31:0] e;
        model_step();
        @(posedge sclk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, pack(ws, tx_rd_en, tx_mask, rx_wr_en, int'(bit_cnt), busy,
                            underrun, overflow, frame_cnt), e);
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic do_start(input string tag, input logic [1:0] sd, input logic fs,
                            input logic [1:0] wsz, input logic st);
        standard = sd; frame_size = fs; word_size = wsz; stereo = st;
        start = 1'b1;
        tick(tag);
        start = 1'b0;
    endtask

    task automatic stop_and_wait(input string tag);
        int guard;
        stop = 1'b1;
        guard = 0;
        while (busy && guard < 200) begin
            tick(tag);
            guard++;
        end
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; standard = 2'd1; frame_size = 0;
        word_size = 0; stereo = 1; tx_empty = 0; rx_full = 0;
        run("reset", 3);
        check("reset_ws", {31'b0, ws}, 32'd1);
        check("reset_mask", {31'b0, tx_mask}, 32'd1);
        rst = 1'b0;
        run("idle", 2);

        // MSB, L=16, W=16, stereo; stop asserted at left bit 5 of frame 1.
        do_start("msb16", 2'd1, 1'b0, 2'd0, 1'b1);
        run("msb16", 17);
        check("msb16_ws_c18", {31'b0, ws}, 32'd1);
        run("msb16", 16);
        check("msb16_fcnt_c34", {16'b0, frame_cnt}, 32'd1);
        run("msb16", 5);
        stop_and_wait("msb16_stop");
        start = 1'b1; stop = 1'b1;
        run("start_and_stop", 3);
        check("start_and_stop_busy", {31'b0, busy}, 32'd0);
        start = 1'b0; stop = 1'b0;

        // Philips, L=32, W=24; configuration changes while busy must be ignored.
        do_start("phil32", 2'd0, 1'b1, 2'd1, 1'b1);
        standard = 2'd2; word_size = 2'd0; stereo = 1'b0;
        run("phil32", 32);
        check("phil32_ws_c33", {31'b0, ws}, 32'd1);
        run("phil32", 100);
        stop_and_wait("phil32_stop");

        // LSB, L=32, W=16, mono.
        do_start("lsb32mono", 2'd2, 1'b1, 2'd0, 1'b0);
        run("lsb32mono", 140);
        stop_and_wait("lsb32mono_stop");

        // W=32 clamped into a 16-bit slot, LSB.
        do_start("lsbclamp", 2'd2, 1'b0, 2'd2, 1'b1);
        run("lsbclamp", 40);
        stop_and_wait("lsbclamp_stop");

        // Underrun before the second frame (sampled in cycle 33).
        do_start("underrun", 2'd1, 1'b0, 2'd0, 1'b1);
        run("underrun", 32);
        tx_empty = 1'b1;
        tick("underrun");
        tx_empty = 1'b0;
        check("underrun_pulse_c34", {31'b0, underrun}, 32'd1);
        run("underrun", 40);
        stop_and_wait("underrun_stop");

        // Reset in mid-left slot, then restart.
        do_start("midrst", 2'd3, 1'b0, 2'd1, 1'b1);
        run("midrst", 8);
        rst = 1'b1;
        tick("midrst_rst");
        check("midrst_fcnt", {16'b0, frame_cnt}, 32'd0);
        rst = 1'b0;
        do_start("midrst_restart", 2'd1, 1'b0, 2'd0, 1'b1);
        run("midrst_restart", 20);
        stop_and_wait("midrst_stop");

        // Random FIFO flags and configurations.
        for (int k = 0; k < 4; k++) begin
            do_start("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 300; i++) begin
                tx_empty  = ($urandom_range(0, 7) == 0);
                rx_full   = ($urandom_range(0, 7) == 0);
                standard  = 2'($urandom_range(0, 3));
                stereo    = 1'($urandom_range(0, 1));
                tick("random");
            end
            tx_empty = 1'b0; rx_full = 1'b0;
            stop_and_wait("random_stop");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
